// File: rtl/host_cycle_sequencer_if.sv
// host_cycle_sequencer_if: CPU-side and host-side signals of the host cycle sequencer
interface host_cycle_sequencer_if;
  logic       cpld_phi0;
  logic       cpu_vda;
  logic       cpu_vpa;
  logic       cpu_rnw;
  logic       host_sel;
  logic       cpu_cycle_end;
  logic [7:0] cpld_d;
  logic       cpu_rdy;
  logic       bbc_rnw;
  logic       bbc_addr_en;
  logic       bbc_d_oe;
  logic [7:0] rd_data;
  logic       timeout;
  modport master (
    output cpld_phi0, cpu_vda, cpu_vpa, cpu_rnw, host_sel, cpu_cycle_end, cpld_d,
    input  cpu_rdy, bbc_rnw, bbc_addr_en, bbc_d_oe, rd_data, timeout
  );
  modport slave (
    input  cpld_phi0, cpu_vda, cpu_vpa, cpu_rnw, host_sel, cpu_cycle_end, cpld_d,
    output cpu_rdy, bbc_rnw, bbc_addr_en, bbc_d_oe, rd_data, timeout
  );
endinterface

// File: rtl/host_cycle_sequencer.sv
// host_cycle_sequencer: stalls the CPU and runs one whole host phi1/phi2 bus cycle per host access
module host_cycle_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                  hsclk,
  input  logic                  cpld_rstb,
  host_cycle_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_FALL, PHI1, PHI2, HOLD, DONE} state_t;
  state_t st, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic p0s, p0s_prev, rise, fall, req, rnw_l, abort, active, hold_end;
  logic cpu_rdy, bbc_rnw, bbc_addr_en, bbc_d_oe, timeout;
  logic [7:0] wd, hc, rd_data;
  assign p0s  = sync[SYNC_STAGES-1];
  assign rise = ~p0s_prev & p0s;
  assign fall = p0s_prev & ~p0s;
  assign req  = (bus.cpu_vda | bus.cpu_vpa) & bus.host_sel;
  assign bus.cpu_rdy     = cpu_rdy;
  assign bus.bbc_rnw     = bbc_rnw;
  assign bus.bbc_addr_en = bbc_addr_en;
  assign bus.bbc_d_oe    = bbc_d_oe;
  assign bus.rd_data     = rd_data;
  assign bus.timeout     = timeout;
  // state register; reset drops straight to IDLE so host pins release at once
  always_ff @(posedge hsclk or negedge cpld_rstb)
    if (!cpld_rstb) st <= IDLE;
    else st <= nxt;
  // next state, watchdog abort and host pin enables
  always_comb begin
    nxt      = st;
    abort    = 1'b0;
    active   = st == PHI1 || st == PHI2 || st == HOLD;
    hold_end = st == HOLD && hc == 8'(HOLD_CYCLES - 1);
    case (st)
      IDLE:      nxt = req ? WAIT_FALL : IDLE;
      WAIT_FALL: if (fall) nxt = PHI1; else abort = wd == 8'(TIMEOUT);
      PHI1:      if (rise) nxt = PHI2; else abort = wd == 8'(TIMEOUT);
      PHI2:      if (fall) nxt = HOLD; else abort = wd == 8'(TIMEOUT);
      HOLD:      nxt = hold_end ? DONE : HOLD;
      DONE:      nxt = bus.cpu_cycle_end ? IDLE : DONE;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = DONE;
    cpu_rdy     = !((st == IDLE && req) || st == WAIT_FALL || active);
    bbc_addr_en = active;
    bbc_d_oe    = (st == PHI2 || st == HOLD) && !rnw_l;
    bbc_rnw     = active ? rnw_l : 1'b1;
  end
  // phi0 synchroniser, watchdog/hold counters, read latch and sticky timeout
  always_ff @(posedge hsclk or negedge cpld_rstb)
    if (!cpld_rstb) begin
      sync     <= '0;
      p0s_prev <= 1'b0;
      rnw_l    <= 1'b1;
      wd       <= '0;
      hc       <= '0;
      rd_data  <= 8'hFF;
      timeout  <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], bus.cpld_phi0};
      p0s_prev <= p0s;
      rnw_l    <= st == IDLE && req ? bus.cpu_rnw : rnw_l;
      wd       <= (st == IDLE && req) || rise || fall ? '0 :
                  (st == WAIT_FALL || st == PHI1 || st == PHI2) ? wd + 8'd1 : wd;
      hc       <= st == HOLD ? hc + 8'd1 : '0;
      rd_data  <= abort ? 8'hFF : st == PHI2 && fall && rnw_l ? bus.cpld_d : rd_data;
      timeout  <= abort | (timeout & ~hold_end);
    end
endmodule
